mlaccel_cmdq: RTL
=================

MLACCEL_CMDQ -- requirements
Module: mlaccel_cmdq

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries; a power of two, at least 4.
REQ-002 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: host offers in_insn.
REQ-005 SHALL have port in_ready, output, 1: queue accepts in_insn this cycle.
REQ-006 SHALL have port in_insn, input, 32: instruction word; fields are maddr [31:15], caddr [14:6], opcode [5:0].
REQ-007 SHALL have port cmd_valid, output, 1: instruction offered to the compute pipeline.
REQ-008 SHALL have port cmd_ready, input, 1: compute pipeline accepts cmd_insn.
REQ-009 SHALL have port cmd_insn, output, 32: instruction issued to compute.
REQ-010 SHALL have port compute_busy, input, 1: busy flag of the compute pipeline.
REQ-011 SHALL have port level, output, clog2(DEPTH)+1: current FIFO occupancy.
REQ-012 SHALL have port busy, output, 1: high when level!=0, cmd_valid=1, or the state is not RUN.

Function
REQ-013 SHALL push in_insn when in_valid&&in_ready; in_ready = (level!=DEPTH), with no pop/push bypass when the FIFO is full.
REQ-014 SHALL register cmd_valid/cmd_insn; a word pushed into an empty idle queue in cycle N SHALL appear on cmd_valid in cycle N+1.
REQ-015 SHALL hold cmd_insn stable while cmd_valid&&!cmd_ready; the handshake completes on cmd_valid&&cmd_ready.
REQ-016 SHALL sustain one issue per cycle while cmd_ready=1 and the FIFO is non-empty.
REQ-017 SHALL give a simultaneous push and pop a net level change of 0; pointers SHALL wrap modulo DEPTH.
REQ-018 SHALL use FSM states RUN, SYNC, ARMED and REPEAT.
REQ-019 Opcode 0 (Sync) SHALL be consumed locally, not forwarded, and move RUN to SYNC.
REQ-020 SYNC SHALL stay for at least 2 cycles after entry, then return to RUN in the first cycle compute_busy=0; no issue SHALL occur during SYNC.
REQ-021 Opcode 62 (Repeat) SHALL be consumed locally, latch cnt=insn[14:6] and stride=insn[31:15], and move RUN to ARMED.
REQ-022 In ARMED, the next popped word (any opcode other than 0 or 62) SHALL be issued cnt+1 times in state REPEAT.
REQ-023 Each REPEAT copy k (k=0..cnt) SHALL carry maddr+k*stride modulo 2^17, caddr+k modulo 512, and the opcode unchanged.
REQ-024 The last REPEAT copy's handshake SHALL return the FSM to RUN.
REQ-025 Opcode 0 or 62 popped while ARMED SHALL be dropped, and the FSM SHALL return to RUN.
REQ-026 No FIFO pop SHALL occur during REPEAT or SYNC; pushes SHALL continue subject to REQ-013.
REQ-027 Back-to-back Repeat/Sync words SHALL each cost one cycle, with no issue in that cycle.

Reset
REQ-028 While reset=0 at a clock edge: level=0, pointers=0, cmd_valid=0, cmd_insn=0, state=RUN, cnt=0, stride=0.
REQ-029 While reset=0: in_ready=0, busy=0.
REQ-030 Reset mid-REPEAT or mid-SYNC SHALL discard all queued and pending words with no further issue; in_ready=1 in the first cycle after reset releases.

Configuration
REQ-031 Macro MLACCEL_CMDQ_REPEAT_EN defined: Repeat and the ARMED/REPEAT states SHALL be implemented per REQ-021..REQ-025.
REQ-032 MLACCEL_CMDQ_REPEAT_EN undefined: opcode 62 SHALL be dropped as a one-cycle NOP, the ARMED/REPEAT states SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-033 Push 0x00008043 at cycle 0 into an empty queue with cmd_ready=1 -> cmd_valid=1, cmd_insn=0x00008043 at cycle 1; level=0 at cycle 2.
REQ-034 Push DEPTH+1 words with cmd_ready=0 -> in_ready=0 after word 16; level=16; word 17 is not accepted until one pop.
REQ-035 cmd_ready toggled 1,0,0,1 during a stream -> cmd_insn is held during the 0 cycles; no word is lost or duplicated; order is preserved.
REQ-036 Repeat(cnt=2, stride=4), then word maddr=0x10, caddr=5, opcode=40 -> three issues: maddr 0x10/0x14/0x18, caddr 5/6/7, opcode 40.
REQ-037 Sync with compute_busy=1 for 10 cycles, then 0 -> no issue until the first cycle after compute_busy falls; Sync itself is never on cmd_insn.
REQ-038 reset=0 asserted during the 2nd copy of a Repeat(cnt=5) -> cmd_valid=0 next cycle, level=0, no further copies after release.

Source files
------------

// File: rtl/mlaccel_cmdq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mlaccel_cmdq
// Purpose  : Instruction command queue in front of an ML compute pipeline.
//            Buffers host instructions in a DEPTH-entry FIFO and issues them
//            through a registered valid/ready port. Sync (opcode 0) stalls
//            issue until the compute pipeline drains. Repeat (opcode 62) makes
//            the following word issue cnt+1 times, with its address fields
//            stepped on every copy.
// Config   : MLACCEL_CMDQ_REPEAT_EN - when defined, Repeat and the ARMED and
//            REPEAT states are built. When undefined, opcode 62 is dropped as
//            a one-cycle NOP.
// Ports    : clock        - single clock, rising edge
//            reset        - synchronous, active-low
//            in_valid     - host offers in_insn
//            in_ready     - queue accepts in_insn this cycle
//            in_insn      - {maddr[31:15], caddr[14:6], opcode[5:0]}
//            cmd_valid    - registered instruction offered to compute
//            cmd_ready    - compute accepts cmd_insn
//            cmd_insn     - registered instruction word to compute
//            compute_busy - busy flag of the compute pipeline
//            level        - words held (FIFO plus the word on the cmd port)
//            busy         - queue holds work, or not in RUN
// Revision : 1.0 - initial release
// ============================================================================
module mlaccel_cmdq #(
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_insn,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [31:0]            cmd_insn,
  input  logic                   compute_busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [AW:0] c_PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] c_FULL      = DEPTH[AW:0];
  localparam logic [5:0]  c_OP_SYNC   = 6'd0;
  localparam logic [5:0]  c_OP_REPEAT = 6'd62;

`ifdef MLACCEL_CMDQ_REPEAT_EN
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ARMED  = 2'd2,
    ST_REPEAT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SYNC = 2'd1
  } state_t;
`endif

  logic [31:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;       // one extra bit distinguishes full from empty
  logic [AW:0] r_rd_ptr;
  state_t      r_state;
  state_t      w_state_n;
  logic        r_cmd_valid;
  logic        w_cmd_valid_n;
  logic [31:0] r_cmd_insn;
  logic [31:0] w_cmd_insn_n;
  logic        r_sync_seen;    // set after the first SYNC cycle
  logic        w_sync_seen_n;
`ifdef MLACCEL_CMDQ_REPEAT_EN
  logic [8:0]  r_cnt;
  logic [8:0]  w_cnt_n;
  logic [16:0] r_stride;
  logic [16:0] w_stride_n;
  logic [8:0]  r_k;
  logic [8:0]  w_k_n;
`endif

  logic [AW:0] w_mem_occ;
  logic [AW:0] w_level;
  logic        w_in_ready;
  logic        w_push;
  logic        w_pop;
  logic        w_mem_empty;
  logic [31:0] w_head;
  logic        w_head_ok;
  logic        w_slot_free;
  logic        w_hs;

  // The word on the cmd port still counts as occupancy until it retires, so
  // the queue as a whole never holds more than DEPTH words.
  assign w_mem_occ   = r_wr_ptr - r_rd_ptr;
  assign w_level     = w_mem_occ + {{AW{1'b0}}, r_cmd_valid};
  assign w_in_ready  = reset && (w_level != c_FULL);
  assign w_push      = in_valid && w_in_ready;
  assign w_mem_empty = (w_mem_occ == '0);
  // Bypass an incoming word straight to the head when the memory is empty,
  // so a push into an idle queue is on cmd_valid the following cycle.
  assign w_head      = w_mem_empty ? in_insn : r_mem[r_rd_ptr[AW-1:0]];
  assign w_head_ok   = !w_mem_empty || w_push;
  assign w_slot_free = !r_cmd_valid || cmd_ready;
  assign w_hs        = r_cmd_valid && cmd_ready;

  assign in_ready  = w_in_ready;
  assign cmd_valid = r_cmd_valid;
  assign cmd_insn  = r_cmd_insn;
  assign level     = w_level;
  assign busy      = reset && ((w_level != '0) || r_cmd_valid || (r_state != ST_RUN));

  always_comb begin
    w_state_n     = r_state;
    w_cmd_valid_n = r_cmd_valid;
    w_cmd_insn_n  = r_cmd_insn;
    w_sync_seen_n = r_sync_seen;
    w_pop         = 1'b0;
`ifdef MLACCEL_CMDQ_REPEAT_EN
    w_cnt_n       = r_cnt;
    w_stride_n    = r_stride;
    w_k_n         = r_k;
`endif
    case (r_state)
      ST_RUN: begin
        if (w_hs) w_cmd_valid_n = 1'b0;
        // Every pop, including locally consumed ones, waits for the cmd slot,
        // so SYNC and ARMED are always entered with cmd_valid low.
        if (w_head_ok && w_slot_free) begin
          w_pop = 1'b1;
          if (w_head[5:0] == c_OP_SYNC) begin
            w_state_n     = ST_SYNC;
            w_sync_seen_n = 1'b0;
          end else if (w_head[5:0] == c_OP_REPEAT) begin
`ifdef MLACCEL_CMDQ_REPEAT_EN
            w_cnt_n    = w_head[14:6];
            w_stride_n = w_head[31:15];
            w_state_n  = ST_ARMED;
`endif
          end else begin
            w_cmd_valid_n = 1'b1;
            w_cmd_insn_n  = w_head;
          end
        end
      end
      ST_SYNC: begin
        w_sync_seen_n = 1'b1;
        if (r_sync_seen && !compute_busy) w_state_n = ST_RUN;
      end
`ifdef MLACCEL_CMDQ_REPEAT_EN
      ST_ARMED: begin
        if (w_head_ok) begin
          w_pop = 1'b1;
          if ((w_head[5:0] == c_OP_SYNC) || (w_head[5:0] == c_OP_REPEAT)) begin
            w_state_n = ST_RUN;
          end else begin
            w_cmd_valid_n = 1'b1;
            w_cmd_insn_n  = w_head;
            w_k_n         = 9'd0;
            w_state_n     = ST_REPEAT;
          end
        end
      end
      ST_REPEAT: begin
        if (w_hs) begin
          if (r_k == r_cnt) begin
            w_cmd_valid_n = 1'b0;
            w_state_n     = ST_RUN;
          end else begin
            // Stepping the previous copy equals base + k*stride modulo field width.
            w_k_n        = r_k + 9'd1;
            w_cmd_insn_n = {r_cmd_insn[31:15] + r_stride,
                            r_cmd_insn[14:6] + 9'd1,
                            r_cmd_insn[5:0]};
          end
        end
      end
`endif
      default: w_state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= in_insn;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_insn  <= '0;
      r_sync_seen <= 1'b0;
`ifdef MLACCEL_CMDQ_REPEAT_EN
      r_cnt       <= '0;
      r_stride    <= '0;
      r_k         <= '0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_cmd_valid <= w_cmd_valid_n;
      r_cmd_insn  <= w_cmd_insn_n;
      r_sync_seen <= w_sync_seen_n;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
`ifdef MLACCEL_CMDQ_REPEAT_EN
      r_cnt       <= w_cnt_n;
      r_stride    <= w_stride_n;
      r_k         <= w_k_n;
`endif
    end
  end

endmodule
`default_nettype wire
